// File: rtl/acq_seq_pkg.sv
// ============================================================================
// acq_seq_pkg : shared types for the acquisition sequencer and its result FIFO
// Option: ACQ_SEQ_TIMESTAMP_EN adds a 16-bit timestamp field to each entry.
// Revision: 1.0
// ============================================================================
`default_nettype none

package acq_seq_pkg;

    localparam int DONE_BIT = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } seq_state_e;

    typedef struct packed {
`ifdef ACQ_SEQ_TIMESTAMP_EN
        logic [15:0] timestamp;
`endif
        logic        timeout;
        logic [2:0]  slot;
        logic [31:0] result;
    } acq_entry_t;

    localparam int ENTRY_W = $bits(acq_entry_t);

endpackage

`default_nettype wire

// File: rtl/acq_result_fifo.sv
// ============================================================================
// acq_result_fifo : synchronous first-word-fall-through FIFO with sticky overflow
// Revision: 1.0
// ============================================================================
`default_nettype none

module acq_result_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     overflow_clr,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic             drop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop on the same edge frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/acq_sequencer.sv
// ============================================================================
// acq_sequencer : issues a programmed command list to DataAcquisitionIP and
// queues tagged results for the CPU. Option: ACQ_SEQ_TIMESTAMP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module acq_sequencer
    import acq_seq_pkg::*;
#(
    parameter int NUM_SLOTS      = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int GAP_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          En,
    input  logic                          SlotWrEn,
    input  logic [$clog2(NUM_SLOTS)-1:0]  SlotWrAddr,
    input  logic [31:0]                   SlotWrData,
    input  logic [$clog2(NUM_SLOTS):0]    SlotCount,
    input  logic                          Start,
    input  logic                          Continuous,
    output logic                          Busy,
    output logic [31:0]                   CPUCommand,
    input  logic [31:0]                   ResultForCPU,
    input  logic                          FifoRdEn,
    output logic [ENTRY_W-1:0]            FifoRdData,
    output logic                          FifoEmpty,
    output logic                          FifoFull,
    output logic [$clog2(FIFO_DEPTH):0]   FifoCount,
    output logic                          Overflow,
    input  logic                          OverflowClr
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = IDX_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [31:0]      slots [NUM_SLOTS];
    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      cmd_q, cmd_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] eff_count;
    logic [IDX_W-1:0] idx_next;
    logic             has_next;
    logic             push;
    acq_entry_t       push_entry;

    assign eff_count  = (SlotCount > CNT_W'(NUM_SLOTS)) ? CNT_W'(NUM_SLOTS) : SlotCount;
    assign idx_next   = idx_q + 1'b1;
    assign has_next   = (({1'b0, idx_q} + CNT_W'(1)) < eff_count);
    assign Busy       = (state_q != IDLE);
    assign CPUCommand = cmd_q;

`ifdef ACQ_SEQ_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= '0;
            end
        end else if (SlotWrEn && state_q == IDLE) begin
            slots[SlotWrAddr] <= SlotWrData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cmd_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
        push       = 1'b0;
        push_entry = '0;
        push_entry.slot = 3'(idx_q);
`ifdef ACQ_SEQ_TIMESTAMP_EN
        push_entry.timestamp = ts_cnt;
`endif

        if (!En) begin
            state_d = IDLE;
            cmd_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_d = '0;
                    if (Start && eff_count != '0) begin
                        state_d = RUN;
                        idx_d   = '0;
                        cmd_d   = slots[0];
                        tmo_d   = '0;
                    end
                end
                RUN: begin
                    // Done beats timeout when both land on the same edge.
                    if (ResultForCPU[DONE_BIT]) begin
                        push              = 1'b1;
                        push_entry.result = ResultForCPU;
                        state_d           = GAP;
                        cmd_d             = '0;
                        gap_d             = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        push               = 1'b1;
                        push_entry.timeout = 1'b1;
                        state_d            = GAP;
                        cmd_d              = '0;
                        gap_d              = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        tmo_d = '0;
                        if (has_next) begin
                            state_d = RUN;
                            idx_d   = idx_next;
                            cmd_d   = slots[idx_next];
                        end else if (Continuous) begin
                            state_d = RUN;
                            idx_d   = '0;
                            cmd_d   = slots[0];
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cmd_d   = '0;
                end
            endcase
        end
    end

    acq_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (Clk),
        .rst          (Rst),
        .push         (push),
        .push_data    (push_entry),
        .pop          (FifoRdEn),
        .overflow_clr (OverflowClr),
        .rd_data      (FifoRdData),
        .empty        (FifoEmpty),
        .full         (FifoFull),
        .count        (FifoCount),
        .overflow     (Overflow)
    );

endmodule

`default_nettype wire

// File: tb/tb_acq_sequencer.sv
// ============================================================================
// tb_acq_sequencer : randomized self-checking bench for acq_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_acq_sequencer;

    localparam int NS  = 8;
    localparam int FD  = 16;
    localparam int GPC = 10;
    localparam int TO  = 4096;
`ifdef ACQ_SEQ_TIMESTAMP_EN
    localparam int EW  = 52;
`else
    localparam int EW  = 36;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          En = 1'b0;
    logic          SlotWrEn = 1'b0;
    logic [2:0]    SlotWrAddr = '0;
    logic [31:0]   SlotWrData = '0;
    logic [3:0]    SlotCount = '0;
    logic          Start = 1'b0;
    logic          Continuous = 1'b0;
    logic          Busy;
    logic [31:0]   CPUCommand;
    logic [31:0]   ResultForCPU = '0;
    logic          FifoRdEn = 1'b0;
    logic [EW-1:0] FifoRdData;
    logic          FifoEmpty;
    logic          FifoFull;
    logic [4:0]    FifoCount;
    logic          Overflow;
    logic          OverflowClr = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference model: expected FIFO contents, sticky overflow, slot table.
    logic [35:0] exp_q[$];
    logic        exp_ovf = 1'b0;
    logic [31:0] slot_val [NS];

    acq_sequencer dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .En           (En),
        .SlotWrEn     (SlotWrEn),
        .SlotWrAddr   (SlotWrAddr),
        .SlotWrData   (SlotWrData),
        .SlotCount    (SlotCount),
        .Start        (Start),
        .Continuous   (Continuous),
        .Busy         (Busy),
        .CPUCommand   (CPUCommand),
        .ResultForCPU (ResultForCPU),
        .FifoRdEn     (FifoRdEn),
        .FifoRdData   (FifoRdData),
        .FifoEmpty    (FifoEmpty),
        .FifoFull     (FifoFull),
        .FifoCount    (FifoCount),
        .Overflow     (Overflow),
        .OverflowClr  (OverflowClr)
    );

    always #5 Clk = ~Clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_push(input logic to, input int slot,
                                       input logic [31:0] res, input logic pop_same);
        if (pop_same && exp_q.size() > 0) void'(exp_q.pop_front());
        if (exp_q.size() < FD) exp_q.push_back({to, 3'(slot), res});
        else exp_ovf = 1'b1;
    endfunction

    task automatic write_slot(input int a, input logic [31:0] d);
        SlotWrEn   = 1'b1;
        SlotWrAddr = 3'(a);
        SlotWrData = d;
        @(negedge Clk);
        SlotWrEn   = 1'b0;
        slot_val[a] = d;
    endtask

    task automatic start_seq(input int sc, input logic cont);
        SlotCount  = 4'(sc);
        Continuous = cont;
        Start      = 1'b1;
        @(negedge Clk);
        Start      = 1'b0;
    endtask

    // Called at the negedge where the slot's command is visible for cycle pre+1.
    // lat = visible cycle on which the responder raises done (0 = never).
    task automatic serve_cmd(input int slot, input int lat, input logic [31:0] data,
                             input int pre, input logic pop_same);
        int vis;
        int exp_vis;
        int gap_len;
        logic to;
        checks++;
        if (CPUCommand !== slot_val[slot]) begin
            errors++;
            $display("FAIL cmd[%0d]: got %h expected %h", slot, CPUCommand, slot_val[slot]);
        end
        vis = pre;
        while (CPUCommand !== 32'h0 && vis < TO + 4) begin
            vis++;
            if (vis == lat) begin
                ResultForCPU = {1'b1, data[30:0]};
                if (pop_same) FifoRdEn = 1'b1;
            end
            @(negedge Clk);
            FifoRdEn = 1'b0;
        end
        ResultForCPU = '0;
        to      = (lat == 0 || lat > TO);
        exp_vis = to ? TO : lat;
        checks++;
        if (vis != exp_vis) begin
            errors++;
            $display("FAIL run_len[%0d]: got %0d cycles expected %0d", slot, vis, exp_vis);
        end
        model_push(to, slot, to ? 32'h0 : {1'b1, data[30:0]}, pop_same);
        gap_len = 0;
        while (CPUCommand === 32'h0 && Busy === 1'b1 && gap_len < GPC + 4) begin
            gap_len++;
            @(negedge Clk);
        end
        checks++;
        if (gap_len != GPC) begin
            errors++;
            $display("FAIL gap_len[%0d]: got %0d expected %0d", slot, gap_len, GPC);
        end
        checks++;
        if (FifoCount !== 5'(exp_q.size()) || Overflow !== exp_ovf) begin
            errors++;
            $display("FAIL fifo_state[%0d]: count %0d ovf %b expected %0d %b",
                     slot, FifoCount, Overflow, exp_q.size(), exp_ovf);
        end
        if (exp_q.size() > 0) begin
            checks++;
            if (FifoRdData[35:0] !== exp_q[0]) begin
                errors++;
                $display("FAIL fifo_head: got %h expected %h", FifoRdData[35:0], exp_q[0]);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (FifoEmpty !== 1'b0 || FifoRdData[35:0] !== exp_q[0]) begin
                errors++;
                $display("FAIL drain[%0d]: got %h empty %b expected %h",
                         i, FifoRdData[35:0], FifoEmpty, exp_q[0]);
            end
            FifoRdEn = 1'b1;
            @(negedge Clk);
            FifoRdEn = 1'b0;
            void'(exp_q.pop_front());
        end
        FifoRdEn = 1'b1;
        @(negedge Clk);
        FifoRdEn = 1'b0;
        checks++;
        if (FifoEmpty !== 1'b1 || FifoCount !== 5'd0 || FifoRdData !== '0) begin
            errors++;
            $display("FAIL drain_empty: empty %b count %0d data %h expected 1 0 0",
                     FifoEmpty, FifoCount, FifoRdData);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (CPUCommand !== 32'h0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_ctl: cmd %h busy %b expected 0 0", tag, CPUCommand, Busy);
        end
        checks++;
        if (FifoEmpty !== 1'b1 || FifoFull !== 1'b0 || FifoCount !== 5'd0) begin
            errors++;
            $display("FAIL %s_fifo: empty %b full %b count %0d expected 1 0 0",
                     tag, FifoEmpty, FifoFull, FifoCount);
        end
        checks++;
        if (Overflow !== 1'b0 || FifoRdData !== '0) begin
            errors++;
            $display("FAIL %s_data: ovf %b data %h expected 0 0", tag, Overflow, FifoRdData);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        En  = 1'b1;
        for (int i = 0; i < NS; i++) slot_val[i] = '0;
        check_reset_values("reset");
    endtask

    task automatic test_single();
        write_slot(0, 32'h8810_0000);
        start_seq(1, 1'b0);
        serve_cmd(0, 20, 32'h8000_1234, 0, 1'b0);
        checks++;
        if (FifoRdData[35:0] !== 36'h0_8000_1234 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL single: data %h busy %b expected 080001234 0", FifoRdData[35:0], Busy);
        end
        drain();
    endtask

    task automatic test_multi();
        for (int i = 0; i < 3; i++) write_slot(i, $urandom() | 32'h1);
        start_seq(3, 1'b0);
        // Write attempted while busy must not alter slot 2.
        SlotWrEn   = 1'b1;
        SlotWrAddr = 3'd2;
        SlotWrData = ~slot_val[2];
        @(negedge Clk);
        SlotWrEn   = 1'b0;
        serve_cmd(0, int'($urandom_range(3, 30)), $urandom(), 1, 1'b0);
        serve_cmd(1, int'($urandom_range(1, 30)), $urandom(), 0, 1'b0);
        serve_cmd(2, int'($urandom_range(1, 30)), $urandom(), 0, 1'b0);
        drain();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 3; i++) write_slot(i, $urandom() | 32'h1);
        start_seq(3, 1'b0);
        serve_cmd(0, 0, 32'h0, 0, 1'b0);
        serve_cmd(1, TO, $urandom(), 0, 1'b0);
        serve_cmd(2, 7, $urandom(), 0, 1'b0);
        drain();
    endtask

    task automatic test_overflow();
        write_slot(0, $urandom() | 32'h1);
        write_slot(1, $urandom() | 32'h1);
        start_seq(2, 1'b1);
        for (int i = 0; i < FD + 1; i++) begin
            serve_cmd(i % 2, int'($urandom_range(1, 8)), $urandom(), 0, 1'b0);
            if (i == FD - 1) begin
                checks++;
                if (FifoFull !== 1'b1 || Overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL fill: full %b ovf %b expected 1 0", FifoFull, Overflow);
                end
            end
        end
        OverflowClr = 1'b1;
        @(negedge Clk);
        OverflowClr = 1'b0;
        exp_ovf = 1'b0;
        checks++;
        if (Overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b expected 0", Overflow);
        end
        serve_cmd(1, 5, $urandom(), 1, 1'b1);
        checks++;
        if (FifoFull !== 1'b1 || FifoCount !== 5'd16) begin
            errors++;
            $display("FAIL push_pop_full: full %b count %0d expected 1 16", FifoFull, FifoCount);
        end
    endtask

    task automatic test_en_abort();
        Continuous = 1'b0;
        En = 1'b0;
        @(negedge Clk);
        checks++;
        if (CPUCommand !== 32'h0 || Busy !== 1'b0 || FifoCount !== 5'(exp_q.size())) begin
            errors++;
            $display("FAIL en_abort: cmd %h busy %b count %0d expected 0 0 %0d",
                     CPUCommand, Busy, FifoCount, exp_q.size());
        end
        start_seq(1, 1'b0);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL start_en_low: busy %b expected 0", Busy);
        end
        En = 1'b1;
        repeat (2) @(negedge Clk);
        drain();
        start_seq(0, 1'b0);
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || CPUCommand !== 32'h0) begin
            errors++;
            $display("FAIL start_zero: busy %b cmd %h expected 0 0", Busy, CPUCommand);
        end
    endtask

    task automatic test_random_runs();
        int sc;
        int eff;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NS; i++) write_slot(i, $urandom() | 32'h1);
            sc  = (r == 0) ? 12 : int'($urandom_range(1, NS));
            eff = (sc > NS) ? NS : sc;
            start_seq(sc, 1'b0);
            for (int k = 0; k < eff; k++)
                serve_cmd(k, int'($urandom_range(1, 25)), $urandom(), 0, 1'b0);
            checks++;
            if (Busy !== 1'b0) begin
                errors++;
                $display("FAIL run_end[%0d]: busy %b expected 0", r, Busy);
            end
            drain();
        end
    endtask

    task automatic test_reset_gap();
        write_slot(0, 32'h1234_5678);
        start_seq(1, 1'b0);
        ResultForCPU = 32'h8000_0042;
        @(negedge Clk);
        ResultForCPU = '0;
        checks++;
        if (CPUCommand !== 32'h0 || Busy !== 1'b1 || FifoCount !== 5'd1) begin
            errors++;
            $display("FAIL pre_reset_gap: cmd %h busy %b count %0d expected 0 1 1",
                     CPUCommand, Busy, FifoCount);
        end
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check_reset_values("reset_gap");
        Rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_timeout();
        test_overflow();
        test_en_abort();
        test_random_runs();
        test_reset_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
